// File: rtl/ex_unit_if.sv
// Execute-stage bus: instruction/operand inputs, writeback result, pc redirect and data-memory port.
// Width comes from the shared XLEN_WIDTH define (32 for RV32I).
`ifndef XLEN_WIDTH
`define XLEN_WIDTH 32
`endif

interface ex_unit_if;
    logic [31:0]              inst;
    logic [`XLEN_WIDTH-1:0]   regs_in1;
    logic [`XLEN_WIDTH-1:0]   regs_in2;
    logic [`XLEN_WIDTH-1:0]   regs_write_data;
    logic [`XLEN_WIDTH-1:0]   pc;
    logic                     pc_jump;
    logic [`XLEN_WIDTH-1:0]   pc_jump_addr;
    logic [`XLEN_WIDTH-1:0]   mem_read_addr;
    logic [`XLEN_WIDTH-1:0]   mem_read_data;
    logic                     mem_write_en;
    logic [`XLEN_WIDTH-1:0]   mem_write_data;
    logic [`XLEN_WIDTH-1:0]   mem_write_addr;

    modport master (
        output inst, regs_in1, regs_in2, pc, mem_read_data,
        input  regs_write_data, pc_jump, pc_jump_addr,
               mem_read_addr, mem_write_en, mem_write_data, mem_write_addr
    );

    modport slave (
        input  inst, regs_in1, regs_in2, pc, mem_read_data,
        output regs_write_data, pc_jump, pc_jump_addr,
               mem_read_addr, mem_write_en, mem_write_data, mem_write_addr
    );
endinterface

// File: rtl/ex_unit.sv
// Combinational RV32I execute stage: ALU, branch/jump resolution and load/store lane handling.
// Define EX_MUL_EN to add RV32M MUL/MULH/MULHSU/MULHU; otherwise funct7=0000001 decodes as unknown.
`ifndef XLEN_WIDTH
`define XLEN_WIDTH 32
`endif

module ex_unit (
    input  logic      clk,
    input  logic      rst,
    ex_unit_if.slave  bus
);
    localparam int XLEN = `XLEN_WIDTH;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Nothing here is clocked; the memory samples the store strobe on its own clock.
    logic unused_clk;
    assign unused_clk = clk;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] rs1, rs2, pc;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] ld_addr, st_addr;

    assign opcode = bus.inst[6:0];
    assign f3     = bus.inst[14:12];
    assign f7     = bus.inst[31:25];
    assign rs1    = bus.regs_in1;
    assign rs2    = bus.regs_in2;
    assign pc     = bus.pc;

    assign imm_i = {{20{bus.inst[31]}}, bus.inst[31:20]};
    assign imm_s = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
    assign imm_b = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7], bus.inst[30:25],
                    bus.inst[11:8], 1'b0};
    assign imm_u = {bus.inst[31:12], 12'b0};
    assign imm_j = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12], bus.inst[20],
                    bus.inst[30:21], 1'b0};

    assign ld_addr = rs1 + imm_i;
    assign st_addr = rs1 + imm_s;

    function automatic logic [XLEN-1:0] alu(input logic [2:0] op, input logic alt,
                                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                            input logic [4:0] shamt);
        logic signed [XLEN-1:0] a_s, b_s;
        logic [XLEN-1:0]        r;
        a_s = a;
        b_s = b;
        r   = '0;
        case (op)
            3'b000: r = alt ? a - b : a + b;
            3'b001: r = a << shamt;
            3'b010: r = {31'b0, a_s < b_s};
            3'b011: r = {31'b0, a < b};
            3'b100: r = a ^ b;
            3'b101: begin
                if (alt) r = a_s >>> shamt;
                else     r = a >> shamt;
            end
            3'b110: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic branch_taken(input logic [2:0] op,
                                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] a_s, b_s;
        a_s = a;
        b_s = b;
        case (op)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return a_s < b_s;
            3'b101:  return a_s >= b_s;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Memory always returns the aligned word; pick the lane out of it.
    function automatic logic [XLEN-1:0] load_extract(input logic [2:0] op, input logic [1:0] off,
                                                     input logic [XLEN-1:0] word);
        logic [7:0]  b8;
        logic [15:0] h16;
        b8  = word[{off, 3'b000} +: 8];
        h16 = off[1] ? word[31:16] : word[15:0];
        case (op)
            3'b000:  return {{24{b8[7]}}, b8};
            3'b001:  return {{16{h16[15]}}, h16};
            3'b100:  return {24'b0, b8};
            3'b101:  return {16'b0, h16};
            default: return word;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_merge(input logic [2:0] op, input logic [1:0] off,
                                                    input logic [XLEN-1:0] word,
                                                    input logic [XLEN-1:0] src);
        logic [XLEN-1:0] r;
        r = word;
        case (op)
            3'b000: r[{off, 3'b000} +: 8] = src[7:0];
            3'b001: begin
                if (off[1]) r[31:16] = src[15:0];
                else        r[15:0]  = src[15:0];
            end
            default: r = src;
        endcase
        return r;
    endfunction

`ifdef EX_MUL_EN
    logic signed [63:0] mul_a, mul_b, mul_p;
    // MULH/MULHSU treat rs1 as signed, only MULH treats rs2 as signed.
    assign mul_a = (f3 != 3'b011) ? {{32{rs1[31]}}, rs1} : {32'b0, rs1};
    assign mul_b = (f3 == 3'b001) ? {{32{rs2[31]}}, rs2} : {32'b0, rs2};
    assign mul_p = mul_a * mul_b;
`endif

    logic [XLEN-1:0] wdata, jump_addr, rd_addr, wr_data, wr_addr;
    logic            jump, wr_en;

    always_comb begin
        wdata     = '0;
        jump      = 1'b0;
        jump_addr = '0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_data   = '0;
        wr_addr   = '0;
        if (!rst) begin
            case (opcode)
                OPC_LUI:   wdata = imm_u;
                OPC_AUIPC: wdata = pc + imm_u;
                OPC_JAL: begin
                    wdata     = pc + 32'd4;
                    jump      = 1'b1;
                    jump_addr = pc + imm_j;
                end
                OPC_JALR: begin
                    wdata     = pc + 32'd4;
                    jump      = 1'b1;
                    jump_addr = (rs1 + imm_i) & ~32'd1;
                end
                OPC_BRANCH: begin
                    if (branch_taken(f3, rs1, rs2)) begin
                        jump      = 1'b1;
                        jump_addr = pc + imm_b;
                    end
                end
                OPC_LOAD: begin
                    if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
                        rd_addr = ld_addr;
                        wdata   = load_extract(f3, ld_addr[1:0], bus.mem_read_data);
                    end
                end
                OPC_STORE: begin
                    if (!f3[2] && f3[1:0] != 2'b11) begin
                        rd_addr = st_addr;
                        wr_addr = st_addr;
                        wr_en   = 1'b1;
                        wr_data = store_merge(f3, st_addr[1:0], bus.mem_read_data, rs2);
                    end
                end
                OPC_OPIMM: wdata = alu(f3, (f3 == 3'b101) && bus.inst[30], rs1, imm_i,
                                       bus.inst[24:20]);
                OPC_OP: begin
                    if (f7 == 7'b0000001) begin
`ifdef EX_MUL_EN
                        if (!f3[2]) wdata = (f3 == 3'b000) ? mul_p[31:0] : mul_p[63:32];
`endif
                    end else begin
                        wdata = alu(f3, bus.inst[30], rs1, rs2, rs2[4:0]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.regs_write_data = wdata;
    assign bus.pc_jump         = jump;
    assign bus.pc_jump_addr    = jump_addr;
    assign bus.mem_read_addr   = rd_addr;
    assign bus.mem_write_en    = wr_en;
    assign bus.mem_write_data  = wr_data;
    assign bus.mem_write_addr  = wr_addr;
endmodule

// File: tb/tb_ex_unit.sv
// Directed-vector bench for ex_unit; instructions hand-encoded, expectations hand-computed.
module tb_ex_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_unit_if bus ();

    ex_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [161:0] all_out;
    assign all_out = {bus.regs_write_data, bus.pc_jump, bus.pc_jump_addr, bus.mem_read_addr,
                      bus.mem_write_en, bus.mem_write_data, bus.mem_write_addr};

    // Apply inputs just after the falling edge and let the combinational outputs settle.
    task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] md);
        @(negedge clk);
        bus.inst          = i;
        bus.pc            = p;
        bus.regs_in1      = a;
        bus.regs_in2      = b;
        bus.mem_read_data = md;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32'h00500093, 32'h0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (all_out !== 162'b0) begin
            errors++; $display("FAIL reset_all_zero got=%h want=0", all_out);
        end
        rst = 1'b0;
        drive(32'h00500093, 32'h0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (bus.regs_write_data !== 32'd5) begin
            errors++; $display("FAIL addi_after_reset got=%h want=5", bus.regs_write_data);
        end
        checks++;
        if (bus.pc_jump !== 1'b0 || bus.mem_write_en !== 1'b0) begin
            errors++; $display("FAIL addi_ctrl got=%b%b want=00", bus.pc_jump, bus.mem_write_en);
        end
    endtask

    task automatic test_alu();
        drive(32'hFFF08113, 32'h0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (bus.regs_write_data !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL addi_neg got=%h want=ffffffff", bus.regs_write_data);
        end
        drive(32'h402081B3, 32'h0, 32'd3, 32'd5, 32'h0);
        checks++;
        if (bus.regs_write_data !== 32'hFFFFFFFE) begin
            errors++; $display("FAIL sub got=%h want=fffffffe", bus.regs_write_data);
        end
        drive(32'h4040D193, 32'h0, 32'h80000000, 32'h0, 32'h0);
        checks++;
        if (bus.regs_write_data !== 32'hF8000000) begin
            errors++; $display("FAIL srai got=%h want=f8000000", bus.regs_write_data);
        end
        drive(32'h0020B1B3, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h0);
        checks++;
        if (bus.regs_write_data !== 32'd1) begin
            errors++; $display("FAIL sltu got=%h want=1", bus.regs_write_data);
        end
        drive(32'h0020A1B3, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h0);
        checks++;
        if (bus.regs_write_data !== 32'd0) begin
            errors++; $display("FAIL slt got=%h want=0", bus.regs_write_data);
        end
    endtask

    task automatic test_branch_jump();
        drive(32'hFE208CE3, 32'h10, 32'd7, 32'd7, 32'h0);
        checks++;
        if (bus.pc_jump !== 1'b1 || bus.pc_jump_addr !== 32'h08) begin
            errors++; $display("FAIL beq_taken got=%b/%h want=1/00000008", bus.pc_jump, bus.pc_jump_addr);
        end
        checks++;
        if (bus.regs_write_data !== 32'h0) begin
            errors++; $display("FAIL beq_wdata got=%h want=0", bus.regs_write_data);
        end
        drive(32'hFE209CE3, 32'h10, 32'd7, 32'd7, 32'h0);
        checks++;
        if (bus.pc_jump !== 1'b0 || bus.pc_jump_addr !== 32'h0) begin
            errors++; $display("FAIL bne_not_taken got=%b/%h want=0/0", bus.pc_jump, bus.pc_jump_addr);
        end
        drive(32'h000080E7, 32'h10, 32'h101, 32'h0, 32'h0);
        checks++;
        if (bus.pc_jump !== 1'b1 || bus.pc_jump_addr !== 32'h100) begin
            errors++; $display("FAIL jalr_target got=%b/%h want=1/00000100", bus.pc_jump, bus.pc_jump_addr);
        end
        checks++;
        if (bus.regs_write_data !== 32'h14) begin
            errors++; $display("FAIL jalr_link got=%h want=14", bus.regs_write_data);
        end
        drive(32'h010000EF, 32'h10, 32'h0, 32'h0, 32'h0);
        checks++;
        if (bus.pc_jump_addr !== 32'h20 || bus.regs_write_data !== 32'h14) begin
            errors++; $display("FAIL jal got=%h/%h want=00000020/00000014", bus.pc_jump_addr, bus.regs_write_data);
        end
    endtask

    task automatic test_load();
        drive(32'h00108183, 32'h0, 32'h20, 32'h0, 32'h80FF7F01);
        checks++;
        if (bus.regs_write_data !== 32'h0000007F || bus.mem_read_addr !== 32'h21) begin
            errors++; $display("FAIL lb_21 got=%h@%h want=0000007f@00000021", bus.regs_write_data, bus.mem_read_addr);
        end
        drive(32'h00308183, 32'h0, 32'h20, 32'h0, 32'h80FF7F01);
        checks++;
        if (bus.regs_write_data !== 32'hFFFFFF80) begin
            errors++; $display("FAIL lb_23 got=%h want=ffffff80", bus.regs_write_data);
        end
        drive(32'h0020D183, 32'h0, 32'h20, 32'h0, 32'h80FF7F01);
        checks++;
        if (bus.regs_write_data !== 32'h000080FF) begin
            errors++; $display("FAIL lhu_22 got=%h want=000080ff", bus.regs_write_data);
        end
        drive(32'h00209183, 32'h0, 32'h20, 32'h0, 32'h80FF7F01);
        checks++;
        if (bus.regs_write_data !== 32'hFFFF80FF) begin
            errors++; $display("FAIL lh_22 got=%h want=ffff80ff", bus.regs_write_data);
        end
        drive(32'h0030A183, 32'h0, 32'h20, 32'h0, 32'h80FF7F01);
        checks++;
        if (bus.regs_write_data !== 32'h80FF7F01 || bus.mem_read_addr !== 32'h23) begin
            errors++; $display("FAIL lw_23 got=%h@%h want=80ff7f01@00000023", bus.regs_write_data, bus.mem_read_addr);
        end
        checks++;
        if (bus.mem_write_en !== 1'b0 || bus.mem_write_addr !== 32'h0) begin
            errors++; $display("FAIL lw_no_store got=%b/%h want=0/0", bus.mem_write_en, bus.mem_write_addr);
        end
    endtask

    task automatic test_store();
        drive(32'h00208123, 32'h0, 32'h20, 32'hAB, 32'h11223344);
        checks++;
        if (bus.mem_write_en !== 1'b1 || bus.mem_write_data !== 32'h11AB3344) begin
            errors++; $display("FAIL sb_data got=%b/%h want=1/11ab3344", bus.mem_write_en, bus.mem_write_data);
        end
        checks++;
        if (bus.mem_write_addr !== 32'h22 || bus.mem_read_addr !== 32'h22) begin
            errors++; $display("FAIL sb_addr got=%h/%h want=00000022/00000022", bus.mem_write_addr, bus.mem_read_addr);
        end
        checks++;
        if (bus.regs_write_data !== 32'h0 || bus.pc_jump !== 1'b0) begin
            errors++; $display("FAIL sb_side got=%h/%b want=0/0", bus.regs_write_data, bus.pc_jump);
        end
        drive(32'h00209123, 32'h0, 32'h20, 32'h1234BEEF, 32'h11223344);
        checks++;
        if (bus.mem_write_data !== 32'hBEEF3344) begin
            errors++; $display("FAIL sh_data got=%h want=beef3344", bus.mem_write_data);
        end
    endtask

    task automatic test_system();
        drive(32'h00000073, 32'h40, 32'h5, 32'h6, 32'h1234);
        checks++;
        if (all_out !== 162'b0) begin
            errors++; $display("FAIL ecall_zero got=%h want=0", all_out);
        end
    endtask

    task automatic test_mul();
`ifdef EX_MUL_EN
        drive(32'h022091B3, 32'h0, 32'hFFFFFFFF, 32'd2, 32'h0);
        checks++;
        if (bus.regs_write_data !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL mulh got=%h want=ffffffff", bus.regs_write_data);
        end
        drive(32'h0220B1B3, 32'h0, 32'hFFFFFFFF, 32'd2, 32'h0);
        checks++;
        if (bus.regs_write_data !== 32'h00000001) begin
            errors++; $display("FAIL mulhu got=%h want=00000001", bus.regs_write_data);
        end
        drive(32'h022081B3, 32'h0, 32'hFFFFFFFF, 32'd2, 32'h0);
        checks++;
        if (bus.regs_write_data !== 32'hFFFFFFFE) begin
            errors++; $display("FAIL mul got=%h want=fffffffe", bus.regs_write_data);
        end
`else
        drive(32'h022081B3, 32'h0, 32'hFFFFFFFF, 32'd2, 32'h0);
        checks++;
        if (all_out !== 162'b0) begin
            errors++; $display("FAIL mul_disabled got=%h want=0", all_out);
        end
`endif
    endtask

    initial begin
        rst               = 1'b1;
        bus.inst          = '0;
        bus.pc            = '0;
        bus.regs_in1      = '0;
        bus.regs_in2      = '0;
        bus.mem_read_data = '0;
        test_reset();
        test_alu();
        test_branch_jump();
        test_load();
        test_store();
        test_system();
        test_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_unit.md
Name: ex_unit

Overview:
- Combinational RV32I execute stage of the single-issue core.
- Sits after ifu/id. Inputs: the current instruction, its pc and the two register-file read values.
- Outputs: the writeback value (register write enable and address come from id), the branch/jump redirect to pc, and the data-memory read/write interface.

Parameters:
- XLEN, 32, data/address width (shared XLEN_WIDTH define; fixed, not overridable).

Ports:
- clk  in  1  clock; no internal state is clocked.
- rst  in  1  synchronous active-high reset qualifier.
- inst  in  32  instruction being executed.
- regs_in1  in  32  rs1 value.
- regs_in2  in  32  rs2 value.
- regs_write_data  out  32  result for rd.
- pc  in  32  address of inst.
- pc_jump  out  1  redirect request.
- pc_jump_addr  out  32  redirect target.
- mem_read_addr  out  32  byte address to data memory.
- mem_read_data  in  32  aligned word returned the same cycle.
- mem_write_en  out  1  store strobe, sampled by memory at posedge clk.
- mem_write_data  out  32  full merged word to write.
- mem_write_addr  out  32  byte address of store.

Behaviour:
- All outputs are purely combinational from the inputs; zero latency.
- While rst=1, every output is 0, so no register or memory write happens at that clock edge.
- Unknown opcode, FENCE, ECALL and EBREAK: all outputs 0.
- Immediates follow RV32I I/S/B/U/J formats, sign-extended to 32 bits.
- LUI: wdata = U-immediate.
- AUIPC: wdata = pc + U-immediate.
- OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - Shift amount = inst[24:20]; inst[30] selects SRAI.
  - SLTIU compares unsigned against the sign-extended immediate.
- OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - Shift amount = regs_in2[4:0].
  - All arithmetic wraps modulo 2^32.
- JAL: wdata = pc+4; pc_jump=1; target = pc + J-immediate.
- JALR: wdata = pc+4; pc_jump=1; target = (regs_in1 + I-immediate) with bit0 cleared.
- Branches (BEQ, BNE, BLT, BGE, BLTU, BGEU):
  - Taken: pc_jump=1, target = pc + B-immediate.
  - Not taken: pc_jump=0, target=0.
  - wdata=0 in both cases.
- Loads: addr = regs_in1 + I-immediate, driven on mem_read_addr.
  - Memory returns the word at addr with bits [1:0] cleared.
  - LW: whole word; addr[1:0] ignored.
  - LH/LHU: halfword selected by addr[1], sign- or zero-extended; addr[0] ignored.
  - LB/LBU: byte selected by addr[1:0], sign- or zero-extended.
- Stores: addr = regs_in1 + S-immediate.
  - mem_read_addr = mem_write_addr = addr; mem_write_en=1.
  - mem_write_data = mem_read_data with the addressed byte/half/word replaced by the low bits of regs_in2 (read-modify-write).
  - Lane rules and ignored bits are the same as for loads.
  - wdata=0.
- Non-memory instructions: mem_write_en=0; mem_read_addr=0; mem_write_addr=0; mem_write_data=0.
- Non-jump instructions: pc_jump=0, pc_jump_addr=0.
- rd=x0 needs no handling here (regs ignores writes to x0).

Optional Feature:
- Macro EX_MUL_EN.
- Defined: OP with funct7=0000001 implements RV32M MUL, MULH, MULHSU, MULHU.
  - MUL gives the low 32 bits; the others give the high 32 bits of the signed×signed, signed×unsigned or unsigned×unsigned 64-bit product.
  - DIV/DIVU/REM/REMU (funct3 100-111) give wdata=0.
- Undefined: every funct7=0000001 encoding is treated as unknown, so all outputs are 0.

Test Plan:
- rst=1 with inst=0x00500093 (addi x1,x0,5) -> every output 0. Then rst=0, regs_in1=0 -> regs_write_data=5, pc_jump=0, mem_write_en=0.
- addi x2,x1,-1 (0xFFF08113), regs_in1=0 -> wdata=0xFFFFFFFF. sub with regs_in1=3, regs_in2=5 -> 0xFFFFFFFE. srai by 4 of 0x80000000 -> 0xF8000000. sltu 1<0xFFFFFFFF -> 1.
- pc=0x10: beq taken with equal operands and imm=-8 -> pc_jump=1, target=0x08. bne with equal operands -> pc_jump=0. jalr with regs_in1=0x101 and imm=0 -> target=0x100, wdata=0x14.
- Load word 0x80FF7F01 at address 0x20:
  - lb at 0x21 -> 0x0000007F.
  - lb at 0x23 -> 0xFFFFFF80.
  - lhu at 0x22 -> 0x000080FF.
  - lw at 0x23 -> 0x80FF7F01.
- sb, regs_in2=0xAB, address 0x22, mem_read_data=0x11223344 -> mem_write_en=1, mem_write_data=0x11AB3344, mem_write_addr=0x22.
- With EX_MUL_EN: mulh 0xFFFFFFFF×2 -> 0xFFFFFFFF; mulhu of the same operands -> 0x00000001. Without EX_MUL_EN: mul -> all outputs 0.
